// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 16-point FFT pipeline (loader and round modules).
package fft_pkg;

  localparam int FFT_N     = 16;
  localparam int FFT_LOG2N = 4;

  // Q19 fixed-point constants, also used by the round modules' twiddle tables
  localparam int Q19_ONE       = 524287;
  localparam int Q19_MINUS_ONE = -524288;

  function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/fft_input_loader.sv
// Serial-to-parallel 16-sample frame loader with registered valid/ready frame output.
// Define FFT_INPUT_BITREV_EN to store sample n in slot bitrev4(n) for DIT ordering.
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_first,
  input  logic [DATA_WIDTH-1:0]        in_real,
  input  logic [DATA_WIDTH-1:0]        in_imag,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic [DATA_WIDTH*FFT_N-1:0]  x_out_flat_real,
  output logic [DATA_WIDTH*FFT_N-1:0]  x_out_flat_imag,
  output logic                         sync_err
);

  localparam logic [FFT_LOG2N-1:0] LAST = FFT_LOG2N'(FFT_N - 1);

  logic [FFT_LOG2N-1:0]        cnt;
  logic [FFT_LOG2N-1:0]        slot;
  logic [DATA_WIDTH-1:0]       fill_real [FFT_N];
  logic [DATA_WIDTH-1:0]       fill_imag [FFT_N];
  logic [DATA_WIDTH*FFT_N-1:0] next_flat_real;
  logic [DATA_WIDTH*FFT_N-1:0] next_flat_imag;
  logic                        accept;
  logic                        restart;
  logic                        complete;

  // Only the frame-completing sample can stall; earlier samples go to the fill buffer.
  assign in_ready = ~rst & ~((cnt == LAST) & frame_valid & ~frame_ready);
  assign accept   = in_valid & in_ready;
  assign restart  = accept & in_first;
  assign complete = accept & ~in_first & (cnt == LAST);

`ifdef FFT_INPUT_BITREV_EN
  assign slot = restart ? '0 : bitrev4(cnt);
`else
  assign slot = restart ? '0 : cnt;
`endif

  // Fill buffer with the incoming sample merged in, so the 16th sample reaches the output
  // on the same edge it is accepted.
  always_comb begin
    next_flat_real = '0;
    next_flat_imag = '0;
    for (int i = 0; i < FFT_N; i++) begin
      next_flat_real[DATA_WIDTH*(FFT_N-i)-1 -: DATA_WIDTH] =
        (accept && slot == FFT_LOG2N'(i)) ? in_real : fill_real[i];
      next_flat_imag[DATA_WIDTH*(FFT_N-i)-1 -: DATA_WIDTH] =
        (accept && slot == FFT_LOG2N'(i)) ? in_imag : fill_imag[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      x_out_flat_real <= '0;
      x_out_flat_imag <= '0;
      frame_valid     <= 1'b0;
      sync_err        <= 1'b0;
      for (int i = 0; i < FFT_N; i++) begin
        fill_real[i] <= '0;
        fill_imag[i] <= '0;
      end
    end else begin
      sync_err <= restart && (cnt != '0);
      if (accept) begin
        fill_real[slot] <= in_real;
        fill_imag[slot] <= in_imag;
        cnt             <= restart ? FFT_LOG2N'(1) : cnt + FFT_LOG2N'(1);
      end
      if (complete) begin
        x_out_flat_real <= next_flat_real;
        x_out_flat_imag <= next_flat_imag;
        frame_valid     <= 1'b1;
      end else if (frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: driver tasks feed samples, a scoreboard queue holds
// expected frames and a monitor compares every presented frame.
module tb_fft_input_loader;

  localparam int DW = 20;
  localparam int N  = 16;
  localparam int FW = DW * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_first;
  logic [DW-1:0] in_real;
  logic [DW-1:0] in_imag;
  logic          frame_valid;
  logic          frame_ready;
  logic [FW-1:0] x_out_flat_real;
  logic [FW-1:0] x_out_flat_imag;
  logic          sync_err;

  fft_input_loader #(.DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_first        (in_first),
    .in_real         (in_real),
    .in_imag         (in_imag),
    .frame_valid     (frame_valid),
    .frame_ready     (frame_ready),
    .x_out_flat_real (x_out_flat_real),
    .x_out_flat_imag (x_out_flat_imag),
    .sync_err        (sync_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [2*FW-1:0] exp_q[$];
  logic [DW-1:0]   m_real [N];
  logic [DW-1:0]   m_imag [N];
  int              mcnt = 0;
  int              checks = 0;
  int              failures = 0;
  int              pops = 0;
  int              sync_pulses = 0;

  function automatic int slot_of(input int n);
    logic [3:0] v;
    v = 4'(n);
`ifdef FFT_INPUT_BITREV_EN
    return int'({v[0], v[1], v[2], v[3]});
`else
    return int'(v);
`endif
  endfunction

  function automatic logic [2*FW-1:0] pack_model();
    logic [FW-1:0] r;
    logic [FW-1:0] im;
    r = '0;
    im = '0;
    for (int i = 0; i < N; i++) begin
      r[DW*(N-i)-1 -: DW]  = m_real[i];
      im[DW*(N-i)-1 -: DW] = m_imag[i];
    end
    return {r, im};
  endfunction

  function automatic longint slot_real(input int i);
    return longint'($signed(x_out_flat_real[DW*(N-i)-1 -: DW]));
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [DW-1:0] r, input logic [DW-1:0] im, input logic f);
    if (f) begin
      m_real[slot_of(0)] = r;
      m_imag[slot_of(0)] = im;
      mcnt = 1;
    end else begin
      m_real[slot_of(mcnt)] = r;
      m_imag[slot_of(mcnt)] = im;
      if (mcnt == N - 1) begin
        exp_q.push_back(pack_model());
        mcnt = 0;
      end else begin
        mcnt++;
      end
    end
  endtask

  // driver tasks: called just after a falling edge, return at a falling edge
  task automatic wait_accept(input logic [DW-1:0] r, input logic [DW-1:0] im, input logic f);
    int t;
    t = 0;
    #1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready=0 expected 1 within 50 cycles at %0t", $time);
      in_valid = 1'b0;
      in_first = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(r, im, f);
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic send(input int r, input int im, input logic f);
    in_valid = 1'b1;
    in_real  = DW'(r);
    in_imag  = DW'(im);
    in_first = f;
    wait_accept(DW'(r), DW'(im), f);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // monitor: compares whatever frame is presented, pops on handoff
  always @(negedge clk) begin
    #2;
    if (!rst && frame_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL frame_unexpected: frame_valid=1 with empty expected queue at %0t", $time);
      end else begin
        checks++;
        if ({x_out_flat_real, x_out_flat_imag} !== exp_q[0]) begin
          failures++;
          $display("FAIL frame_data: got %h expected %h", x_out_flat_real, exp_q[0][2*FW-1 -: FW]);
        end
        if (frame_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
    if (!rst && sync_err) sync_pulses++;
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_real = '0;
    in_imag = '0;
    frame_ready = 1'b1;

    // 1: reset
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_frame_valid", longint'(frame_valid), 0);
    chk("rst_bus_real_zero", longint'(x_out_flat_real == '0), 1);
    chk("rst_bus_imag_zero", longint'(x_out_flat_imag == '0), 1);
    chk("rst_sync_err", longint'(sync_err), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", longint'(in_ready), 1);

    // 2: basic frame, natural data real=n imag=-n
    for (int n = 0; n < N; n++) send(n, -n, n == 0);
    chk("t2_latency_valid", longint'(frame_valid), 1);
`ifdef FFT_INPUT_BITREV_EN
    chk("t2_slot8_real", slot_real(8), 1);
`else
    chk("t2_slot8_real", slot_real(8), 8);
`endif
    chk("t2_slot15_real", slot_real(15), 15);
    idle(1);
    chk("t2_valid_one_cycle", longint'(frame_valid), 0);

    // 3: backpressure across two frames
    frame_ready = 1'b0;
    for (int n = 0; n < N; n++) send(32 + n, n, 1'b0);
    chk("t3_a_valid", longint'(frame_valid), 1);
    for (int n = 0; n < N - 1; n++) send(64 + n, 2 * n, 1'b0);
    in_valid = 1'b1;
    in_real  = DW'(64 + 15);
    in_imag  = DW'(30);
    in_first = 1'b0;
    #1;
    chk("t3_stall_in_ready", longint'(in_ready), 0);
    @(negedge clk);
    #1;
    chk("t3_stall_in_ready_2", longint'(in_ready), 0);
    chk("t3_a_stable_slot0", slot_real(0), 32);
    frame_ready = 1'b1;
    wait_accept(DW'(64 + 15), DW'(30), 1'b0);
    chk("t3_b_loaded_valid", longint'(frame_valid), 1);
    chk("t3_b_slot0", slot_real(0), 64);
    idle(2);
    chk("t3_drained", longint'(frame_valid), 0);

    // 4: resync with in_first mid-frame
    for (int n = 0; n < 5; n++) send(300 + n, n, n == 0);
    chk("t4_no_err_yet", longint'(sync_pulses), 0);
    send(100, 7, 1'b1);
    chk("t4_sync_err_pulse", longint'(sync_err), 1);
    idle(1);
    chk("t4_sync_err_drop", longint'(sync_err), 0);
    for (int k = 1; k < N; k++) send(100 + k, k, 1'b0);
    chk("t4_frame_valid", longint'(frame_valid), 1);
    chk("t4_slot0_real", slot_real(0), 100);
    idle(2);

    // 5: reset in the middle of a frame
    for (int n = 0; n < 10; n++) send(400 + n, n, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("t5_rst_in_ready", longint'(in_ready), 0);
    chk("t5_rst_frame_valid", longint'(frame_valid), 0);
    rst = 1'b0;
    mcnt = 0;
    for (int n = 0; n < N; n++) send(500 + n, -(500 + n), 1'b0);
    chk("t5_frame_valid", longint'(frame_valid), 1);
    chk("t5_slot0_real", slot_real(0), 500);
    idle(2);

    // 6: full-scale extremes
    for (int n = 0; n < N; n++) send(-524288, 524287, 1'b0);
    chk("t6_slot15_real", slot_real(15), -524288);
    chk("t6_slot0_imag", longint'($signed(x_out_flat_imag[FW-1 -: DW])), 524287);
    idle(3);

    chk("end_frames_handed_off", longint'(pops), 6);
    chk("end_queue_empty", longint'(exp_q.size()), 0);
    chk("end_sync_pulses", longint'(sync_pulses), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
